div_32_bit_seq: RTL and testbench



---
 rtl/div_32_bit_seq_pkg.sv | 31 +++
 rtl/div_32_bit_seq_sub_33_bit.sv | 15 +
 rtl/div_32_bit_seq.sv | 135 +++++++++++++
 tb/tb_div_32_bit_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/div_32_bit_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential signed divider.
// The result layout matches the Booth multiplier's HI/LO register pair.
package div_32_bit_seq_pkg;

    localparam int WORD_W = 32;
    localparam int ITER   = 32;
    localparam int CNT_W  = 5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    localparam logic [WORD_W-1:0] DIVZ_QUOTIENT = 32'hFFFF_FFFF;

    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_FIX  = 3'd2,
        ST_DIVZ = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Unsigned magnitude; -2^31 maps to 0x8000_0000 without overflow.
    function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v);
        return v[WORD_W-1] ? (~v + WORD_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_32_bit_seq_sub_33_bit.sv
// Combinational 33-bit trial subtractor: low 32 bits of a-b plus the sign of the result.
module sub_33_bit (
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [31:0] diff,
    output logic        neg
);

    logic [32:0] full;

    assign full = a - b;
    assign diff = full[31:0];
    assign neg  = full[32];

endmodule

// File: rtl/div_32_bit_seq.sv
// Sequential signed 32-bit restoring divider; result is {remainder, quotient}.
// Division runs on magnitudes over 32 iterations, then signs are applied in FIX.
module div_32_bit_seq
    import div_32_bit_seq_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] rslt
);

    state_t state_reg, state_next;

    logic [CNT_W-1:0]  cnt_reg;
    logic [WORD_W-1:0] rem_reg;
    logic [WORD_W-1:0] quo_reg;
    logic [WORD_W-1:0] div_mag_reg;
    logic [WORD_W-1:0] dividend_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              dbz_reg;
    logic [2*WIDTH-1:0] rslt_reg;

    logic [32:0]       trial_a;
    logic [32:0]       trial_b;
    logic [WORD_W-1:0] trial_diff;
    logic              trial_neg;
    logic [WORD_W-1:0] q_fix;
    logic [WORD_W-1:0] r_fix;

    // Partial remainder shifted left with the next dividend bit from the top of Q.
    assign trial_a = {rem_reg, quo_reg[WORD_W-1]};
    assign trial_b = {1'b0, div_mag_reg};

    sub_33_bit u_sub (
        .a    (trial_a),
        .b    (trial_b),
        .diff (trial_diff),
        .neg  (trial_neg)
    );

    assign q_fix = neg_q_reg ? (~quo_reg + WORD_W'(1)) : quo_reg;
    assign r_fix = neg_r_reg ? (~rem_reg + WORD_W'(1)) : rem_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (y == '0) ? ST_DIVZ : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_reg == '0) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX:  state_next = ST_DONE;
            ST_DIVZ: state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            div_mag_reg  <= '0;
            dividend_reg <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            dbz_reg      <= 1'b0;
            rslt_reg     <= '0;
        end else begin
            state_reg <= state_next;
            // done trails the DONE state by one cycle so it coincides with busy falling.
            done_reg  <= (state_reg == ST_DONE);
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        dividend_reg <= x;
                        rem_reg      <= '0;
                        quo_reg      <= magnitude(x);
                        div_mag_reg  <= magnitude(y);
                        neg_q_reg    <= x[WORD_W-1] ^ y[WORD_W-1];
                        neg_r_reg    <= x[WORD_W-1];
                        cnt_reg      <= LAST_ITER;
                        busy_reg     <= 1'b1;
                        dbz_reg      <= 1'b0;
                    end
                end
                ST_CALC: begin
                    rem_reg <= trial_neg ? trial_a[WORD_W-1:0] : trial_diff;
                    quo_reg <= {quo_reg[WORD_W-2:0], ~trial_neg};
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
                ST_FIX: begin
                    rslt_reg[HI_MSB:HI_LSB] <= r_fix;
                    rslt_reg[LO_MSB:LO_LSB] <= q_fix;
                end
                ST_DIVZ: begin
                    rslt_reg[HI_MSB:HI_LSB] <= dividend_reg;
                    rslt_reg[LO_MSB:LO_LSB] <= DIVZ_QUOTIENT;
                    dbz_reg                 <= 1'b1;
                end
                ST_DONE: begin
                    busy_reg <= 1'b0;
                end
                default: begin
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign rslt        = rslt_reg;

endmodule

// File: tb/tb_div_32_bit_seq.sv
// Self-checking bench: latency/result model built from signed arithmetic, compared every cycle.
module tb_div_32_bit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] rslt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    div_32_bit_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .x           (x),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .rslt        (rslt)
    );

    // Truncating signed division; remainder follows the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-level model: remaining cycles until done, result visible one cycle before done.
    int          remain_m;
    logic        busy_m, done_m, dbz_m, pend_dbz;
    logic [63:0] rslt_m, pend_rslt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_m  <= 0;
            busy_m    <= 1'b0;
            done_m    <= 1'b0;
            dbz_m     <= 1'b0;
            rslt_m    <= '0;
            pend_rslt <= '0;
            pend_dbz  <= 1'b0;
        end else begin
            done_m <= 1'b0;
            if (remain_m == 0) begin
                if (start) begin
                    pend_rslt <= ref_div(x, y);
                    pend_dbz  <= (y == 32'd0);
                    remain_m  <= (y == 32'd0) ? 2 : 34;
                    busy_m    <= 1'b1;
                    dbz_m     <= 1'b0;
                end
            end else begin
                remain_m <= remain_m - 1;
                if (remain_m == 2) begin
                    rslt_m <= pend_rslt;
                    dbz_m  <= pend_dbz;
                end
                if (remain_m == 1) begin
                    busy_m <= 1'b0;
                    done_m <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(busy_m));
        chk("done", 64'(done), 64'(done_m));
        chk("div_by_zero", 64'(div_by_zero), 64'(dbz_m));
        chk("rslt", rslt, rslt_m);
    end

    task automatic run_dir(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input logic exp_dbz, input int lat);
        bit seen;
        @(posedge clk); #2;
        x = a; y = b; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        seen = 1'b0;
        for (int n = 1; n <= lat + 5 && !seen; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk({nm, "_busy_start"}, 64'(busy), 64'd1);
                chk({nm, "_dbz_cleared"}, 64'(div_by_zero), 64'd0);
            end
            if (done) begin
                seen = 1'b1;
                chk({nm, "_latency"}, 64'(n), 64'(lat + 1));
                chk({nm, "_rslt"}, rslt, exp);
                chk({nm, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
            end
        end
        if (!seen) chk({nm, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_done(input string nm, input int limit, input bit scramble);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (scramble) begin
                x = $urandom;
                y = $urandom;
            end
        end
        if (!seen) chk({nm, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        logic [31:0] rx, ry;
        bit hold;

        chk("model_100_7", ref_div(32'd100, 32'd7), 64'h0000_0002_0000_000E);
        chk("model_m100_7", ref_div(32'hFFFF_FF9C, 32'd7), 64'hFFFF_FFFE_FFFF_FFF2);
        chk("model_100_m7", ref_div(32'd100, 32'hFFFF_FFF9), 64'h0000_0002_FFFF_FFF2);
        chk("model_min_m1", ref_div(32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("model_55_0", ref_div(32'd55, 32'd0), 64'h0000_0037_FFFF_FFFF);

        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rslt", rslt, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        run_dir("pos_pos", 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 34);
        run_dir("neg_pos", 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2, 1'b0, 34);
        run_dir("pos_neg", 32'd100, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, 1'b0, 34);
        run_dir("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 34);
        run_dir("max_by_1", 32'h7FFF_FFFF, 32'd1, 64'h0000_0000_7FFF_FFFF, 1'b0, 34);
        run_dir("divz", 32'd55, 32'd0, 64'h0000_0037_FFFF_FFFF, 1'b1, 2);
        run_dir("after_divz", 32'd9, 32'd3, 64'h0000_0000_0000_0003, 1'b0, 34);

        // Start and operand changes while busy must be ignored.
        @(posedge clk); #2;
        x = 32'd100; y = 32'd7; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 x = 32'd9; y = 32'd3; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done("ignore", 40, 1'b1);
        chk("ignore_rslt", rslt, 64'h0000_0002_0000_000E);
        repeat (40) @(posedge clk);

        // Asynchronous abort in the middle of a division.
        #2 x = 32'd100; y = 32'd7; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_rslt", rslt, 64'd0);
        #10 rst_n = 1'b1;
        run_dir("post_abort", 32'd9, 32'd3, 64'h0000_0000_0000_0003, 1'b0, 34);

        // Randomized operations with corner operands, scrambled inputs and held start.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = 32'd1;
                2: ry = 32'hFFFF_FFFF;
                3: ry = $urandom_range(1, 15);
                4: ry = 32'h8000_0000;
                default: ry = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rx = 32'h8000_0000;
                1: rx = 32'h7FFF_FFFF;
                2: rx = $urandom_range(0, 200);
                default: rx = $urandom;
            endcase
            hold = ($urandom_range(0, 4) == 0);
            @(posedge clk); #2;
            x = rx; y = ry; start = 1'b1;
            @(posedge clk); #2;
            if (!hold) start = 1'b0;
            wait_done("rand", 40, 1'b1);
            if (hold) begin
                @(posedge clk); #2;
                start = 1'b0;
                wait_done("rand_hold", 40, 1'b1);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
